bnn_run_ctrl: RTL and testbench
===============================

BNN_RUN_CTRL -- requirements
Module: bnn_run_ctrl

Interface
REQ-001 Parameter NUM_PIXELS, 784, number of image bytes written per run.
REQ-002 Parameter OUT_BASE, 1024, activation-memory address of class-0 output.
REQ-003 Parameter NUM_CLASSES, 10, number of output scores read back.
REQ-004 Parameter RD_LATENCY, 2, cycles from bnn_rd_addr change to valid bnn_act_out.
REQ-005 Parameter START_CYCLES, 2, width of bnn_start pulse in cycles.
REQ-006 Parameter TIMEOUT, 50000, max cycles waiting for bnn_done (16-bit counter).
REQ-007 One clock; reset is synchronous and active-high; ports are named clk and rst.
REQ-008 clk  in  1  system clock, all logic on rising edge.
REQ-009 rst  in  1  synchronous active-high reset.
REQ-010 go  in  1  single-cycle run request; sampled only in IDLE.
REQ-011 pix_valid  in  1, pix_data  in  8, pix_ready  out  1: pixel stream handshake.
REQ-012 bnn_wr_en  out  1, bnn_wr_addr  out  11, bnn_wr_data  out  8: activation-memory write port.
REQ-013 bnn_start  out  1  accelerator start.
REQ-014 bnn_done  in  1  accelerator done (level).
REQ-015 bnn_rd_addr  out  11, bnn_act_out  in  8 (signed): output readback.
REQ-016 res_valid  out  1, res_ready  in  1, res_class  out  4, res_score  out  8 (signed), res_timeout  out  1: result handshake.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, LOAD, START, WAIT, READ, RESULT; transitions only as listed below.
REQ-019 IDLE: go=1 -> LOAD, pixel counter cleared to 0; go in any other state is ignored.
REQ-020 LOAD: pix_ready=1 (combinational from state); a transfer occurs when pix_valid&pix_ready.
REQ-021 Write is combinational pass-through: bnn_wr_en=pix_valid&pix_ready, bnn_wr_addr=counter, bnn_wr_data=pix_data; zero-extended 10-bit counter.
REQ-022 Counter increments per transfer; transfer at counter=NUM_PIXELS-1 -> START next cycle; pix_ready=0 outside LOAD.
REQ-023 pix_valid gaps stall LOAD indefinitely with no write and no counter change.
REQ-024 START: bnn_start=1 for exactly START_CYCLES cycles, then -> WAIT; bnn_start=0 in all other states.
REQ-025 WAIT: bnn_done is accepted only as a rising edge (low sampled in WAIT or last START cycle, then high); a done held high from a prior run is ignored.
REQ-026 WAIT: timeout counter counts cycles from WAIT entry; on reaching TIMEOUT without accepted done -> RESULT with res_timeout=1, res_class=4'hF, res_score=0.
REQ-027 Accepted done -> READ; timeout counter cleared.
REQ-028 READ: bnn_rd_addr=OUT_BASE+i for i=0..NUM_CLASSES-1, one new address per cycle (pipelined); bnn_act_out for index i captured RD_LATENCY cycles after its address is driven.
REQ-029 Argmax: signed 8-bit compare; index 0 initialises best; replace only on strictly greater, so ties resolve to lowest index.
REQ-030 After capture of index NUM_CLASSES-1 -> RESULT; READ lasts NUM_CLASSES+RD_LATENCY cycles.
REQ-031 RESULT: res_valid=1 with res_class/res_score/res_timeout stable until res_valid&res_ready, then -> IDLE next cycle; res_ready outside RESULT ignored.
REQ-032 bnn_rd_addr holds its last value outside READ.

Reset
REQ-033 rst=1 at a clock edge forces IDLE from any state including mid-LOAD/WAIT/READ; counters, best index/score cleared.
REQ-034 Reset values: pix_ready=0, bnn_wr_en=0, bnn_wr_addr=0, bnn_wr_data=0, bnn_start=0, bnn_rd_addr=0, res_valid=0, res_class=0, res_score=0, res_timeout=0, busy=0.
REQ-035 Run after reset requires a new go; partial image data is not resumed.

Verification
REQ-036 go, 784 back-to-back pixels -> writes addr 0..783 with matching data, bnn_start high 2 cycles starting the cycle after addr 783 write.
REQ-037 Model done 100 cycles after start, scores {-3,5,12,-128,7,12,0,1,2,3} with 2-cycle latency -> rd_addr 1024..1033 consecutive, res_class=2, res_score=12 (tie vs index 5).
REQ-038 bnn_done held high before go -> no READ until done falls and rises again.
REQ-039 Done never asserted, TIMEOUT=100 -> res_valid after 100 WAIT cycles with res_timeout=1, res_class=15.
REQ-040 rst asserted during WAIT and during LOAD (pixel 300) -> all outputs at reset values next cycle; subsequent full run correct.
REQ-041 res_ready held low 20 cycles -> res_valid and result fields stable; go during that window ignored; pix_valid with random gaps during LOAD -> exactly 784 writes.

Source files
------------

// File: rtl/bnn_run_ctrl.sv
// Run sequencer for the BNN accelerator: streams one image into activation memory, pulses start,
// waits for a fresh done (or times out), reads back the class scores and holds the argmax until taken.
module bnn_run_ctrl #(
   parameter int NUM_PIXELS   = 784,
   parameter int OUT_BASE     = 1024,
   parameter int NUM_CLASSES  = 10,
   parameter int RD_LATENCY   = 2,
   parameter int START_CYCLES = 2,
   parameter int TIMEOUT      = 50000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   input  logic              pix_valid,
   input  logic [7:0]        pix_data,
   output logic              pix_ready,
   output logic              bnn_wr_en,
   output logic [10:0]       bnn_wr_addr,
   output logic [7:0]        bnn_wr_data,
   output logic              bnn_start,
   input  logic              bnn_done,
   output logic [10:0]       bnn_rd_addr,
   input  logic signed [7:0] bnn_act_out,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [3:0]        res_class,
   output logic signed [7:0] res_score,
   output logic              res_timeout,
   output logic              busy
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_READ, S_RESULT} state_t;

   localparam logic [9:0]  PIX_LAST   = 10'(NUM_PIXELS - 1);
   localparam logic [15:0] ST_LAST    = 16'(START_CYCLES - 1);
   localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);
   localparam logic [15:0] CL_LAST    = 16'(NUM_CLASSES - 1);
   localparam logic [15:0] RD_LAT_C   = 16'(RD_LATENCY);
   localparam logic [15:0] RD_LAST    = 16'(NUM_CLASSES + RD_LATENCY - 1);
   localparam logic [10:0] OUT_BASE_C = 11'(OUT_BASE);

   state_t            state_q, state_d;
   logic [9:0]        pix_cnt_q, pix_cnt_d;
   logic [15:0]       cyc_cnt_q, cyc_cnt_d;
   logic              armed_q, armed_d;
   logic [10:0]       rd_addr_q, rd_addr_d;
   logic [3:0]        best_idx_q, best_idx_d;
   logic signed [7:0] best_score_q, best_score_d;
   logic              timeout_q, timeout_d;
   logic              xfer;
   logic              done_acc;
   logic [3:0]        cap_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         pix_cnt_q    <= '0;
         cyc_cnt_q    <= '0;
         armed_q      <= 1'b0;
         rd_addr_q    <= '0;
         best_idx_q   <= '0;
         best_score_q <= '0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         pix_cnt_q    <= pix_cnt_d;
         cyc_cnt_q    <= cyc_cnt_d;
         armed_q      <= armed_d;
         rd_addr_q    <= rd_addr_d;
         best_idx_q   <= best_idx_d;
         best_score_q <= best_score_d;
         timeout_q    <= timeout_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pix_cnt_d    = pix_cnt_q;
      cyc_cnt_d    = cyc_cnt_q;
      armed_d      = armed_q;
      rd_addr_d    = rd_addr_q;
      best_idx_d   = best_idx_q;
      best_score_d = best_score_q;
      timeout_d    = timeout_q;

      pix_ready   = (state_q == S_LOAD);
      xfer        = pix_valid & pix_ready;
      bnn_wr_en   = xfer;
      bnn_wr_addr = {1'b0, pix_cnt_q};
      bnn_wr_data = pix_ready ? pix_data : 8'h00;
      bnn_start   = (state_q == S_START);
      bnn_rd_addr = rd_addr_q;
      res_valid   = (state_q == S_RESULT);
      res_class   = best_idx_q;
      res_score   = best_score_q;
      res_timeout = timeout_q;
      busy        = (state_q != S_IDLE);
      // done only counts once it has been seen low in this run, so a level left over from a prior run is ignored
      done_acc    = (state_q == S_WAIT) && armed_q && bnn_done;
      cap_idx     = 4'(cyc_cnt_q - RD_LAT_C);

      case (state_q)
         S_IDLE: begin
            if (go) begin
               state_d   = S_LOAD;
               pix_cnt_d = '0;
               timeout_d = 1'b0;
            end
         end
         S_LOAD: begin
            if (xfer) begin
               if (pix_cnt_q == PIX_LAST) begin
                  state_d   = S_START;
                  cyc_cnt_d = '0;
                  armed_d   = 1'b0;
               end else begin
                  pix_cnt_d = pix_cnt_q + 10'd1;
               end
            end
         end
         S_START: begin
            if (cyc_cnt_q == ST_LAST) begin
               state_d   = S_WAIT;
               cyc_cnt_d = '0;
               armed_d   = !bnn_done;
            end else begin
               cyc_cnt_d = cyc_cnt_q + 16'd1;
            end
         end
         S_WAIT: begin
            if (done_acc) begin
               state_d   = S_READ;
               cyc_cnt_d = '0;
               rd_addr_d = OUT_BASE_C;
            end else if (cyc_cnt_q == TO_LAST) begin
               state_d      = S_RESULT;
               timeout_d    = 1'b1;
               best_idx_d   = 4'hF;
               best_score_d = 8'sd0;
            end else begin
               cyc_cnt_d = cyc_cnt_q + 16'd1;
               if (!bnn_done) armed_d = 1'b1;
            end
         end
         S_READ: begin
            // address issue and capture overlap: capture trails issue by RD_LATENCY cycles
            cyc_cnt_d = cyc_cnt_q + 16'd1;
            if (cyc_cnt_q < CL_LAST) rd_addr_d = rd_addr_q + 11'd1;
            if (cyc_cnt_q >= RD_LAT_C) begin
               if ((cap_idx == 4'd0) || (bnn_act_out > best_score_q)) begin
                  best_idx_d   = cap_idx;
                  best_score_d = bnn_act_out;
               end
            end
            if (cyc_cnt_q == RD_LAST) begin
               state_d   = S_RESULT;
               cyc_cnt_d = '0;
            end
         end
         S_RESULT: begin
            if (res_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_bnn_run_ctrl.sv
// Scoreboard bench for bnn_run_ctrl: expected writes/results queued at stimulus time, compared on DUT output.
module tb_bnn_run_ctrl;

   localparam int TO = 100;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              go = 1'b0;
   logic              pix_valid = 1'b0;
   logic [7:0]        pix_data = 8'h00;
   logic              pix_ready;
   logic              bnn_wr_en;
   logic [10:0]       bnn_wr_addr;
   logic [7:0]        bnn_wr_data;
   logic              bnn_start;
   logic              bnn_done = 1'b0;
   logic [10:0]       bnn_rd_addr;
   logic signed [7:0] bnn_act_out;
   logic              res_valid;
   logic              res_ready = 1'b0;
   logic [3:0]        res_class;
   logic signed [7:0] res_score;
   logic              res_timeout;
   logic              busy;

   bnn_run_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .go(go),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
      .bnn_wr_en(bnn_wr_en), .bnn_wr_addr(bnn_wr_addr), .bnn_wr_data(bnn_wr_data),
      .bnn_start(bnn_start), .bnn_done(bnn_done),
      .bnn_rd_addr(bnn_rd_addr), .bnn_act_out(bnn_act_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
      .res_score(res_score), .res_timeout(res_timeout), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // activation memory model with two-cycle read latency
   logic [10:0]       a1 = '0, a2 = '0;
   logic signed [7:0] scores [10];
   logic [3:0]        sidx;
   always @(posedge clk) begin
      a1 <= bnn_rd_addr;
      a2 <= a1;
   end
   assign sidx        = 4'(a2 - 11'd1024);
   assign bnn_act_out = (a2 >= 11'd1024 && a2 < 11'd1034) ? scores[sidx] : 8'sh5A;

   int          n_chk = 0, n_err = 0;
   logic [18:0] wr_q [$];
   logic [12:0] res_q [$];
   logic [18:0] wr_e;
   int          n_wr = 0, n_res = 0;
   int          last_wr_cyc = -10, start_cyc = 0, rd_seq = 0, s0 = 0;
   logic        start_prev = 1'b0, seen_read = 1'b0;
   logic [10:0] rd_prev = '0;
   logic [12:0] snap;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic reset_check(input string tag);
      check_val({tag, "_flags"}, {26'd0, pix_ready, bnn_wr_en, bnn_start, res_valid, res_timeout, busy}, 0);
      check_val({tag, "_wr_addr"}, {21'd0, bnn_wr_addr}, 0);
      check_val({tag, "_wr_data"}, {24'd0, bnn_wr_data}, 0);
      check_val({tag, "_rd_addr"}, {21'd0, bnn_rd_addr}, 0);
      check_val({tag, "_class_score"}, {20'd0, res_class, res_score}, 0);
   endtask

   task automatic launch(input bit push, input logic [12:0] exp);
      if (push) res_q.push_back(exp);
      go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      check_val("load_pix_ready", {31'd0, pix_ready}, 1);
      check_val("load_busy", {31'd0, busy}, 1);
   endtask

   task automatic send_pixels(input int n, input bit gaps);
      for (int k = 0; k < n; k++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            pix_valid = 1'b0;
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
         end
         pix_valid = 1'b1;
         pix_data  = 8'(k * 37 + 5);
         wr_q.push_back({11'(k), pix_data});
         @(posedge clk); #1;
      end
      pix_valid = 1'b0;
   endtask

   task automatic wait_start();
      for (int i = 0; i < 50 && !bnn_start; i++) @(negedge clk);
      check_val("start_seen", {31'd0, bnn_start}, 1);
   endtask

   task automatic wait_result(input int limit);
      for (int i = 0; i < limit && !res_valid; i++) @(negedge clk);
      check_val("res_valid_seen", {31'd0, res_valid}, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      scores = '{8'hFD, 8'h05, 8'h0C, 8'h80, 8'h07, 8'h0C, 8'h00, 8'h01, 8'h02, 8'h03};
      fork
         forever begin
            @(negedge clk);
            if (!rst) begin
               if (bnn_wr_en) begin
                  n_wr++;
                  if (wr_q.size() == 0) check_val("wr_unexpected", 1, 0);
                  else begin
                     wr_e = wr_q.pop_front();
                     check_val("wr_addr", {21'd0, bnn_wr_addr}, {21'd0, wr_e[18:8]});
                     check_val("wr_data", {24'd0, bnn_wr_data}, {24'd0, wr_e[7:0]});
                  end
                  if (bnn_wr_addr == 11'd783) last_wr_cyc = cyc;
               end
               if (bnn_start && !start_prev) begin
                  start_cyc = cyc;
                  check_val("start_after_wr783", cyc - last_wr_cyc, 1);
               end
               if (!bnn_start && start_prev) check_val("start_width", cyc - start_cyc, 2);
               if (bnn_rd_addr == 11'd1024 && rd_prev != 11'd1024) begin
                  rd_seq    = 1;
                  seen_read = 1'b1;
               end else if (rd_seq > 0 && rd_seq < 10) begin
                  check_val("rd_addr_seq", {21'd0, bnn_rd_addr}, 1024 + rd_seq);
                  rd_seq++;
               end
               if (res_valid && res_ready) begin
                  n_res++;
                  if (res_q.size() == 0) check_val("res_unexpected", 1, 0);
                  else check_val("result", {19'd0, res_timeout, res_class, res_score}, {19'd0, res_q.pop_front()});
               end
            end
            start_prev = bnn_start;
            rd_prev    = bnn_rd_addr;
         end
      join_none

      repeat (2) @(posedge clk);
      #1;
      reset_check("por");
      rst = 1'b0;
      @(posedge clk); #1;

      // run 1: back-to-back pixels, done 100 cycles after start, tie at index 2/5
      res_ready = 1'b1;
      launch(1'b1, {1'b0, 4'd2, 8'h0C});
      send_pixels(784, 1'b0);
      wait_start();
      repeat (100) @(posedge clk);
      #1 bnn_done = 1'b1;
      wait_result(200);
      @(posedge clk); #1;
      check_val("idle_after_run1", {31'd0, busy}, 0);
      check_val("run1_writes", n_wr, 784);

      // run 2: done still high from run 1, gapped pixels, result held under backpressure
      scores    = '{8'h9C, 8'hCE, 8'hCE, 8'hF9, 8'hF9, 8'h80, 8'hF7, 8'hF8, 8'hC4, 8'hF9};
      res_ready = 1'b0;
      n_wr      = 0;
      seen_read = 1'b0;
      launch(1'b1, {1'b0, 4'd3, 8'hF9});
      send_pixels(784, 1'b1);
      wait_start();
      repeat (40) @(posedge clk);
      #1;
      check_val("no_read_on_held_done", {31'd0, seen_read}, 0);
      check_val("held_done_busy_nores", {30'd0, busy, res_valid}, 2);
      bnn_done = 1'b0;
      repeat (5) @(posedge clk);
      #1 bnn_done = 1'b1;
      wait_result(100);
      check_val("read_after_new_edge", {31'd0, seen_read}, 1);
      snap = {res_timeout, res_class, res_score};
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         go = (i == 5);
         @(negedge clk);
         check_val("hold_valid", {31'd0, res_valid}, 1);
         check_val("hold_fields", {19'd0, res_timeout, res_class, res_score}, {19'd0, snap});
      end
      go = 1'b0;
      @(posedge clk); #1 res_ready = 1'b1;
      @(posedge clk); #1 res_ready = 1'b0;
      check_val("idle_after_accept", {31'd0, busy}, 0);
      @(posedge clk); #1;
      check_val("go_in_result_ignored", {31'd0, busy}, 0);
      check_val("run2_writes", n_wr, 784);

      // run 3: done never arrives
      bnn_done  = 1'b0;
      res_ready = 1'b1;
      launch(1'b1, {1'b1, 4'hF, 8'h00});
      send_pixels(784, 1'b0);
      wait_start();
      s0 = cyc;
      for (int i = 0; i < 300 && !res_valid; i++) @(negedge clk);
      check_val("timeout_latency", cyc - s0, TO + 2);
      @(posedge clk); #1;

      // reset mid-LOAD at pixel 300, then mid-WAIT
      launch(1'b0, '0);
      send_pixels(300, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      reset_check("rst_load");
      rst = 1'b0;
      check_val("wr_q_drained", wr_q.size(), 0);
      @(posedge clk); #1;
      launch(1'b0, '0);
      send_pixels(784, 1'b0);
      wait_start();
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      reset_check("rst_wait");
      rst = 1'b0;
      check_val("no_go_no_run", {31'd0, busy}, 0);
      @(posedge clk); #1;

      // run 4: full run after resets, max at last index
      scores = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h7F};
      n_wr   = 0;
      launch(1'b1, {1'b0, 4'd9, 8'h7F});
      send_pixels(784, 1'b0);
      wait_start();
      repeat (20) @(posedge clk);
      #1 bnn_done = 1'b1;
      wait_result(100);
      @(posedge clk); #1;
      check_val("idle_after_run4", {31'd0, busy}, 0);
      check_val("run4_writes", n_wr, 784);
      check_val("results_all_seen", res_q.size(), 0);
      check_val("result_count", n_res, 4);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
